// File: rtl/pulse_burst_gen.sv
// Pulse burst generator: emits burst_len clean rising edges on pulse_out with per-burst
// programmable high/low widths. Optional abort input when PULSE_BURST_ABORT_EN is defined.
module pulse_burst_gen #(
    parameter int CNT_W    = 4,
    parameter int PERIOD_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
`ifdef PULSE_BURST_ABORT_EN
    input  logic                abort,
`endif
    input  logic [CNT_W-1:0]    burst_len,
    input  logic [PERIOD_W-1:0] high_cyc,
    input  logic [PERIOD_W-1:0] low_cyc,
    output logic                pulse_out,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    sent_cnt,
    output logic [1:0]          dbg_state
);

    // Handshake: start is honoured only in IDLE; done strobes one cycle per accepted start.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [PERIOD_W-1:0] hi_m1_q, hi_m1_d;
    logic [PERIOD_W-1:0] lo_m1_q, lo_m1_d;
    logic [PERIOD_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0]    sent_q, sent_d;
    logic                abort_hit;

    // Widths are stored as terminal count (width-1) so a programmed 0 behaves as 1.
    function automatic logic [PERIOD_W-1:0] term_cnt(input logic [PERIOD_W-1:0] w);
        return (w == '0) ? '0 : w - 1'b1;
    endfunction

`ifdef PULSE_BURST_ABORT_EN
    assign abort_hit = abort && (state == S_HIGH || state == S_LOW);
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d = state;
        len_d   = len_q;
        hi_m1_d = hi_m1_q;
        lo_m1_d = lo_m1_q;
        phase_d = phase_q;
        sent_d  = sent_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    len_d   = burst_len;
                    hi_m1_d = term_cnt(high_cyc);
                    lo_m1_d = term_cnt(low_cyc);
                    sent_d  = '0;
                    phase_d = '0;
                    state_d = (burst_len == '0) ? S_DONE : S_HIGH;
                end
            end
            S_HIGH: begin
                if (abort_hit) begin
                    phase_d = '0;
                    state_d = S_DONE;
                end else if (phase_q == hi_m1_q) begin
                    phase_d = '0;
                    sent_d  = sent_q + 1'b1;
                    state_d = S_LOW;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_LOW: begin
                if (abort_hit) begin
                    phase_d = '0;
                    state_d = S_DONE;
                end else if (phase_q == lo_m1_q) begin
                    phase_d = '0;
                    state_d = (sent_q == len_q) ? S_DONE : S_HIGH;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            len_q   <= '0;
            hi_m1_q <= '0;
            lo_m1_q <= '0;
            phase_q <= '0;
            sent_q  <= '0;
        end else begin
            state   <= state_d;
            len_q   <= len_d;
            hi_m1_q <= hi_m1_d;
            lo_m1_q <= lo_m1_d;
            phase_q <= phase_d;
            sent_q  <= sent_d;
        end
    end

    // Outputs are a registered view of the current state, giving the one-edge start latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            pulse_out <= (state == S_HIGH) && !abort_hit;
            busy      <= (state == S_HIGH) || (state == S_LOW);
            done      <= (state == S_DONE);
        end
    end

    assign sent_cnt  = sent_q;
    assign dbg_state = state;

endmodule
